// File: rtl/bram_port_arbiter.sv
// Two-requester arbiter for a 256x8 block RAM: independent round-robin write and read ports.
// Optional BRAM_ARB_CLEAR_EN: zero the whole memory after reset before accepting requests.
module bram_port_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_w_en,
  output logic [ADDR_W-1:0] mem_w_addr,
  output logic [DATA_W-1:0] mem_w_data,
  output logic              mem_r_en,
  output logic [ADDR_W-1:0] mem_r_addr,
  input  logic [DATA_W-1:0] mem_r_data,
  output logic              busy
);

  // Pointer value 0 favours A, 1 favours B; rd_id 0 = A, 1 = B.
  logic wr_ptr;
  logic rd_ptr;
  logic rd_valid;
  logic rd_id;
  logic arb_ok;

  logic wr_a, wr_b, rd_a, rd_b;
  logic wr_gnt_a, wr_gnt_b, rd_gnt_a, rd_gnt_b;

`ifdef BRAM_ARB_CLEAR_EN
  typedef enum logic {ST_CLEAR, ST_ARB} state_t;
  state_t            state;
  logic [ADDR_W-1:0] clr_addr;
  logic              sweeping;

  assign arb_ok   = !rst && (state == ST_ARB);
  assign sweeping = !rst && (state == ST_CLEAR);
  assign busy     = rst || (state == ST_CLEAR);
`else
  assign arb_ok = !rst;
  assign busy   = 1'b0;
`endif

  assign wr_a = a_req & a_we;
  assign wr_b = b_req & b_we;
  assign rd_a = a_req & ~a_we;
  assign rd_b = b_req & ~b_we;

  assign wr_gnt_a = arb_ok & wr_a & (~wr_b | ~wr_ptr);
  assign wr_gnt_b = arb_ok & wr_b & (~wr_a |  wr_ptr);
  assign rd_gnt_a = arb_ok & rd_a & (~rd_b | ~rd_ptr);
  assign rd_gnt_b = arb_ok & rd_b & (~rd_a |  rd_ptr);

  assign a_gnt = wr_gnt_a | rd_gnt_a;
  assign b_gnt = wr_gnt_b | rd_gnt_b;

  // Suppress a pending return strobe in any cycle where reset is held.
  assign a_rvalid = rd_valid & ~rd_id & ~rst;
  assign b_rvalid = rd_valid &  rd_id & ~rst;
  assign a_rdata  = a_rvalid ? mem_r_data : '0;
  assign b_rdata  = b_rvalid ? mem_r_data : '0;

  always_comb begin
    mem_w_en   = 1'b0;
    mem_w_addr = '0;
    mem_w_data = '0;
    mem_r_en   = 1'b0;
    mem_r_addr = '0;

    if (wr_gnt_a) begin
      mem_w_en   = 1'b1;
      mem_w_addr = a_addr;
      mem_w_data = a_wdata;
    end else if (wr_gnt_b) begin
      mem_w_en   = 1'b1;
      mem_w_addr = b_addr;
      mem_w_data = b_wdata;
    end

    if (rd_gnt_a) begin
      mem_r_en   = 1'b1;
      mem_r_addr = a_addr;
    end else if (rd_gnt_b) begin
      mem_r_en   = 1'b1;
      mem_r_addr = b_addr;
    end

`ifdef BRAM_ARB_CLEAR_EN
    if (sweeping) begin
      mem_w_en   = 1'b1;
      mem_w_addr = clr_addr;
      mem_w_data = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      rd_valid <= 1'b0;
      rd_id    <= 1'b0;
`ifdef BRAM_ARB_CLEAR_EN
      state    <= ST_CLEAR;
      clr_addr <= '0;
`endif
    end else begin
      if (wr_gnt_a | wr_gnt_b)
        wr_ptr <= wr_gnt_a;
      if (rd_gnt_a | rd_gnt_b)
        rd_ptr <= rd_gnt_a;
      rd_valid <= rd_gnt_a | rd_gnt_b;
      rd_id    <= rd_gnt_b;
`ifdef BRAM_ARB_CLEAR_EN
      case (state)
        ST_CLEAR: begin
          clr_addr <= clr_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
          if (clr_addr == {ADDR_W{1'b1}})
            state <= ST_ARB;
        end
        default: state <= ST_ARB;
      endcase
`endif
    end
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed self-checking bench for bram_port_arbiter with a behavioural 256x8 read-before-write RAM.
// Covers both builds of BRAM_ARB_CLEAR_EN.
module tb_bram_port_arbiter;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

`ifdef BRAM_ARB_CLEAR_EN
  localparam logic EXP_BUSY_RST = 1'b1;
`else
  localparam logic EXP_BUSY_RST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic              a_req, a_we, b_req, b_we;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [DATA_W-1:0] a_wdata, b_wdata;
  logic              a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [DATA_W-1:0] a_rdata, b_rdata;
  logic              mem_w_en, mem_r_en, busy;
  logic [ADDR_W-1:0] mem_w_addr, mem_r_addr;
  logic [DATA_W-1:0] mem_w_data, mem_r_data;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] mem [256];

  always #5 clk = ~clk;

  // Registered read with read-before-write on a same-address collision.
  always @(posedge clk) begin
    if (mem_r_en) mem_r_data <= mem[mem_r_addr];
    if (mem_w_en) mem[mem_w_addr] <= mem_w_data;
  end

  bram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_w_en(mem_w_en), .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data),
    .mem_r_en(mem_r_en), .mem_r_addr(mem_r_addr), .mem_r_data(mem_r_data),
    .busy(busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ar, input logic aw, input logic [7:0] aa, input logic [7:0] ad,
                               input logic br, input logic bw, input logic [7:0] ba, input logic [7:0] bd);
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

`ifdef BRAM_ARB_CLEAR_EN
  // Counts busy cycles from the current cycle, noting any grant or read leaking through.
  task automatic measureSweep(output int cnt, output logic leak);
    cnt  = 0;
    leak = 1'b0;
    while (busy && cnt < 400) begin
      if (a_gnt || b_gnt || mem_r_en || (mem_w_en && mem_w_data != 8'h00)) leak = 1'b1;
      cnt++;
      step();
    end
  endtask
`endif

  initial begin
    int   cnt;
    logic leak;
    logic [1:0] exp_w;

    // Requests presented while reset is held must be ignored.
    applyStimulus(1, 1, 8'h44, 8'h99, 1, 0, 8'h55, 8'h00);
    step();
    step();
    checkOutput("rst_a_gnt", a_gnt, 0);
    checkOutput("rst_b_gnt", b_gnt, 0);
    checkOutput("rst_mem_w_en", mem_w_en, 0);
    checkOutput("rst_mem_w_addr", mem_w_addr, 0);
    checkOutput("rst_mem_w_data", mem_w_data, 0);
    checkOutput("rst_mem_r_en", mem_r_en, 0);
    checkOutput("rst_mem_r_addr", mem_r_addr, 0);
    checkOutput("rst_a_rvalid", a_rvalid, 0);
    checkOutput("rst_b_rvalid", b_rvalid, 0);
    checkOutput("rst_a_rdata", a_rdata, 0);
    checkOutput("rst_b_rdata", b_rdata, 0);
    checkOutput("rst_busy", busy, EXP_BUSY_RST);

`ifdef BRAM_ARB_CLEAR_EN
    rst = 1'b0;
    applyStimulus(1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    measureSweep(cnt, leak);
    checkOutput("sweep_len", cnt, 256);
    checkOutput("sweep_no_leak", leak, 0);
    checkOutput("post_sweep_gnt", a_gnt, 1);
    checkOutput("post_sweep_raddr", mem_r_addr, 8'h00);
    step();
    checkOutput("clr_rd00_valid", a_rvalid, 1);
    checkOutput("clr_rd00_data", a_rdata, 8'h00);
    applyStimulus(1, 0, 8'h7F, 8'h00, 0, 0, 8'h00, 8'h00);
    step();
    checkOutput("clr_rd7f_data", a_rdata, 8'h00);
    applyStimulus(1, 0, 8'hFF, 8'h00, 0, 0, 8'h00, 8'h00);
    step();
    checkOutput("clr_rdff_valid", a_rvalid, 1);
    checkOutput("clr_rdff_data", a_rdata, 8'h00);
`else
    rst = 1'b0;
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    checkOutput("nomacro_busy", busy, 0);
`endif

    // Preload through the arbiter: 0x20 <= 0x5A by A, 0x33 <= 0x11 by B.
    applyStimulus(1, 1, 8'h20, 8'h5A, 0, 0, 8'h00, 8'h00);
    checkOutput("pre_a_gnt", a_gnt, 1);
    checkOutput("pre_w_addr", mem_w_addr, 8'h20);
    checkOutput("pre_w_data", mem_w_data, 8'h5A);
    step();
    applyStimulus(0, 0, 8'h00, 8'h00, 1, 1, 8'h33, 8'h11);
    checkOutput("pre_b_gnt", b_gnt, 1);
    checkOutput("pre_b_w_data", mem_w_data, 8'h11);
    step();

    // Concurrent write by A and read by B.
    applyStimulus(1, 1, 8'h10, 8'h61, 1, 0, 8'h20, 8'h00);
    checkOutput("cc_a_gnt", a_gnt, 1);
    checkOutput("cc_b_gnt", b_gnt, 1);
    checkOutput("cc_w_addr", mem_w_addr, 8'h10);
    checkOutput("cc_r_en", mem_r_en, 1);
    checkOutput("cc_r_addr", mem_r_addr, 8'h20);
    step();
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    checkOutput("cc_b_rvalid", b_rvalid, 1);
    checkOutput("cc_b_rdata", b_rdata, 8'h5A);
    checkOutput("cc_a_rvalid", a_rvalid, 0);
    checkOutput("cc_a_rdata", a_rdata, 0);

    // Read contention on 0x33: A first, B the cycle after.
    applyStimulus(1, 0, 8'h33, 8'h00, 1, 0, 8'h33, 8'h00);
    checkOutput("rc1_a_gnt", a_gnt, 1);
    checkOutput("rc1_b_gnt", b_gnt, 0);
    step();
    applyStimulus(0, 0, 8'h00, 8'h00, 1, 0, 8'h33, 8'h00);
    checkOutput("rc2_a_rvalid", a_rvalid, 1);
    checkOutput("rc2_a_rdata", a_rdata, 8'h11);
    checkOutput("rc2_b_gnt", b_gnt, 1);
    step();
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    checkOutput("rc3_b_rvalid", b_rvalid, 1);
    checkOutput("rc3_b_rdata", b_rdata, 8'h11);
    checkOutput("rc3_a_rvalid", a_rvalid, 0);

    // Earlier write of 0x61 to 0x10 is visible.
    applyStimulus(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00);
    step();
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    checkOutput("rd10_data", a_rdata, 8'h61);

    // Same-address read (A) and write (B): read sees old contents.
    applyStimulus(1, 0, 8'h33, 8'h00, 1, 1, 8'h33, 8'h22);
    checkOutput("hz_a_gnt", a_gnt, 1);
    checkOutput("hz_b_gnt", b_gnt, 1);
    step();
    applyStimulus(1, 0, 8'h33, 8'h00, 0, 0, 8'h00, 8'h00);
    checkOutput("hz_old_data", a_rdata, 8'h11);
    step();
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    checkOutput("hz_new_data", a_rdata, 8'h22);

    // Write contention for 4 cycles: A, B, A, B.
    applyStimulus(1, 1, 8'h40, 8'hA1, 1, 1, 8'h41, 8'hB2);
    for (int i = 0; i < 4; i++) begin
      exp_w = (i % 2 == 0) ? 2'b01 : 2'b10;
      checkOutput($sformatf("wc%0d_a_gnt", i), a_gnt, exp_w[0]);
      checkOutput($sformatf("wc%0d_b_gnt", i), b_gnt, exp_w[1]);
      checkOutput($sformatf("wc%0d_w_data", i), mem_w_data, exp_w[0] ? 8'hA1 : 8'hB2);
      step();
    end

    // Back-to-back reads by A.
    applyStimulus(1, 0, 8'h40, 8'h00, 0, 0, 8'h00, 8'h00);
    checkOutput("bb1_a_gnt", a_gnt, 1);
    step();
    applyStimulus(1, 0, 8'h41, 8'h00, 0, 0, 8'h00, 8'h00);
    checkOutput("bb1_rvalid", a_rvalid, 1);
    checkOutput("bb1_rdata", a_rdata, 8'hA1);
    checkOutput("bb2_a_gnt", a_gnt, 1);
    step();
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    checkOutput("bb2_rvalid", a_rvalid, 1);
    checkOutput("bb2_rdata", a_rdata, 8'hB2);

    // Reset in the cycle after a granted read.
    applyStimulus(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00);
    checkOutput("mr_a_gnt", a_gnt, 1);
    step();
    rst = 1'b1;
    #1;
    checkOutput("mr_a_rvalid", a_rvalid, 0);
    checkOutput("mr_a_rdata", a_rdata, 0);
    checkOutput("mr_a_gnt_blocked", a_gnt, 0);
    checkOutput("mr_mem_r_en", mem_r_en, 0);
    checkOutput("mr_busy", busy, EXP_BUSY_RST);
    step();
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    rst = 1'b0;
    #1;
    checkOutput("mr_after_rvalid", a_rvalid, 0);

`ifdef BRAM_ARB_CLEAR_EN
    cnt = 0;
    while (!(mem_w_en && mem_w_addr == 8'd100) && cnt < 400) begin
      cnt++;
      step();
    end
    checkOutput("sw100_reached", (mem_w_en && mem_w_addr == 8'd100), 1);
    rst = 1'b1;
    #1;
    checkOutput("sw100_rst_w_en", mem_w_en, 0);
    step();
    rst = 1'b0;
    #1;
    measureSweep(cnt, leak);
    checkOutput("sweep2_len", cnt, 256);
    checkOutput("sweep2_no_leak", leak, 0);
`else
    applyStimulus(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00);
    checkOutput("post_rst_gnt", a_gnt, 1);
    step();
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    checkOutput("post_rst_data", a_rdata, 8'h61);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] timeout");
  end

endmodule
